stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr_if.sv | 28 ++
 rtl/stream_mux_rr.sv | 84 ++++++++
 tb/tb_stream_mux_rr.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// Stream mux handshake bundle: N valid/ready/data input channels plus one registered output channel.
interface stream_mux_rr_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [SW-1:0]  sel;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;

    // Mux side
    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with a registered output stage, backpressure,
// and either external-select or round-robin arbitration.
module stream_mux_rr #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    stream_mux_rr_if.slave  bus
);
    localparam int unsigned SW = $clog2(N);

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_ch;
    logic [SW-1:0] r_rr_ptr;

    logic          w_load_en;
    logic          w_sel_ok;
    logic          w_rr_ok;
    logic [SW-1:0] w_rr_gnt;
    logic [SW-1:0] w_gnt;
    logic          w_gnt_ok;
    logic [N-1:0]  w_ready;
    logic          w_xfer;
    logic [W-1:0]  w_gnt_data;

    assign w_load_en = !r_out_valid || bus.out_ready;

    // External select: out-of-range values grant nothing
    assign w_sel_ok = (32'(bus.sel) < N) && bus.in_valid[bus.sel];

    // Round-robin: first valid channel after the last one served, with wrap
    always_comb begin
        w_rr_gnt = '0;
        w_rr_ok  = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (32'(r_rr_ptr) + k) % N;
            if (!w_rr_ok && bus.in_valid[SW'(idx)]) begin
                w_rr_gnt = SW'(idx);
                w_rr_ok  = 1'b1;
            end
        end
    end

    assign w_gnt    = (MODE == 0) ? bus.sel  : w_rr_gnt;
    assign w_gnt_ok = (MODE == 0) ? w_sel_ok : w_rr_ok;

    always_comb begin
        w_ready = '0;
        if (!rst && w_load_en && w_gnt_ok) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    assign w_xfer     = |(bus.in_valid & w_ready);
    assign w_gnt_data = bus.in_data[32'(w_gnt) * W +: W];

    // Output register: refill on transfer, otherwise drain when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= SW'(N - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_ch    <= w_gnt;
            if (MODE == 1) begin
                r_rr_ptr <= w_gnt;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: one instance per arbitration mode, shared clock and reset.
module tb_stream_mux_rr;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    stream_mux_rr_if #(.N(N), .W(W)) if0 ();
    stream_mux_rr_if #(.N(N), .W(W)) if1 ();

    stream_mux_rr #(.N(N), .W(W), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    stream_mux_rr #(.N(N), .W(W), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.in_valid = 4'b1111; if0.sel = 2'd0; if0.out_ready = 1'b1;
        if0.in_data = 32'h13121110;
        if1.in_valid = 4'b1111; if1.sel = 2'd0; if1.out_ready = 1'b1;
        if1.in_data = 32'h13121110;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m0_out_valid cyc%0d got=%b exp=0", c, if0.out_valid); end
            n_checks++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m1_out_valid cyc%0d got=%b exp=0", c, if1.out_valid); end
            n_checks++; if (if1.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data cyc%0d got=%h exp=00", c, if1.out_data); end
            n_checks++; if (if1.out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_out_ch cyc%0d got=%0d exp=0", c, if1.out_ch); end
            n_checks++; if (if0.in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_m0_in_ready cyc%0d got=%b exp=0000", c, if0.in_ready); end
            n_checks++; if (if1.in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_m1_in_ready cyc%0d got=%b exp=0000", c, if1.in_ready); end
        end
        rst = 1'b0;
        #1;
        n_checks++; if (if1.in_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant got=%b exp=0001", if1.in_ready); end
        step();
        n_checks++; if (if1.out_ch !== 2'd0 || if1.out_data !== 8'h10) begin n_fail++; $display("FAIL rst_first_word got ch=%0d data=%h exp ch=0 data=10", if1.out_ch, if1.out_data); end
    endtask

    task automatic test_mode0_select();
        if0.in_valid = 4'b0000; if0.out_ready = 1'b1;
        do_reset();
        if0.sel = 2'd2; if0.in_data = 32'h00A50000; if0.in_valid = 4'b0100;
        #1;
        n_checks++; if (if0.in_ready !== 4'b0100) begin n_fail++; $display("FAIL sel2_in_ready got=%b exp=0100", if0.in_ready); end
        step();
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 8'hA5 || if0.out_ch !== 2'd2) begin n_fail++; $display("FAIL sel2_out got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", if0.out_valid, if0.out_data, if0.out_ch); end
        if0.sel = 2'd3;
        #1;
        n_checks++; if (if0.in_ready !== 4'b0000) begin n_fail++; $display("FAIL sel3_invalid_in_ready got=%b exp=0000", if0.in_ready); end
        step();
        n_checks++; if (if0.out_valid !== 1'b0 || if0.out_data !== 8'hA5 || if0.out_ch !== 2'd2) begin n_fail++; $display("FAIL sel3_drain got v=%b d=%h ch=%0d exp v=0 d=a5 ch=2", if0.out_valid, if0.out_data, if0.out_ch); end
        if0.in_valid = 4'b0000;
    endtask

    task automatic test_fairness();
        if1.in_valid = 4'b0000; if1.out_ready = 1'b1; if1.in_data = 32'h13121110;
        do_reset();
        if1.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << (i % 4);
            #1;
            n_checks++; if (if1.in_ready !== exp_rdy) begin n_fail++; $display("FAIL fair_in_ready step%0d got=%b exp=%b", i, if1.in_ready, exp_rdy); end
            step();
            n_checks++; if (if1.out_valid !== 1'b1 || if1.out_ch !== 2'(i % 4) || if1.out_data !== 8'(8'h10 + i % 4)) begin n_fail++; $display("FAIL fair_out step%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, if1.out_valid, if1.out_ch, if1.out_data, i % 4, 8'h10 + i % 4); end
        end
        if1.in_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        if1.in_valid = 4'b0000; if1.out_ready = 1'b1; if1.in_data = 32'h13121110;
        do_reset();
        if1.in_valid = 4'b1111;
        step();
        if1.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (if1.in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_in_ready cyc%0d got=%b exp=0000", c, if1.in_ready); end
            step();
            n_checks++; if (if1.out_valid !== 1'b1 || if1.out_ch !== 2'd0 || if1.out_data !== 8'h10) begin n_fail++; $display("FAIL stall_hold cyc%0d got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", c, if1.out_valid, if1.out_ch, if1.out_data); end
        end
        if1.out_ready = 1'b1;
        #1;
        n_checks++; if (if1.in_ready !== 4'b0010) begin n_fail++; $display("FAIL release_in_ready got=%b exp=0010", if1.in_ready); end
        step();
        n_checks++; if (if1.out_valid !== 1'b1 || if1.out_ch !== 2'd1 || if1.out_data !== 8'h11) begin n_fail++; $display("FAIL release_out got v=%b ch=%0d d=%h exp v=1 ch=1 d=11", if1.out_valid, if1.out_ch, if1.out_data); end
        #1;
        n_checks++; if (if1.in_ready !== 4'b0100) begin n_fail++; $display("FAIL release_next_grant got=%b exp=0100", if1.in_ready); end
        if1.in_valid = 4'b0000;
    endtask

    task automatic test_sparse_rr();
        logic [1:0] exp_ch [3];
        exp_ch[0] = 2'd1; exp_ch[1] = 2'd3; exp_ch[2] = 2'd1;
        if1.in_valid = 4'b0000; if1.out_ready = 1'b1; if1.in_data = 32'h13121110;
        do_reset();
        if1.in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (if1.out_ch !== exp_ch[i] || if1.out_data !== 8'(8'h10 + 32'(exp_ch[i]))) begin n_fail++; $display("FAIL sparse_out step%0d got ch=%0d d=%h exp ch=%0d", i, if1.out_ch, if1.out_data, exp_ch[i]); end
        end
        if1.in_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (if1.in_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_in_ready cyc%0d got=%b exp=0000", c, if1.in_ready); end
            step();
        end
        n_checks++; if (if1.out_valid !== 1'b0 || if1.out_ch !== 2'd1) begin n_fail++; $display("FAIL idle_out got v=%b ch=%0d exp v=0 ch=1", if1.out_valid, if1.out_ch); end
        if1.in_valid = 4'b1010;
        #1;
        n_checks++; if (if1.in_ready !== 4'b1000) begin n_fail++; $display("FAIL resume_grant got=%b exp=1000", if1.in_ready); end
        step();
        n_checks++; if (if1.out_valid !== 1'b1 || if1.out_ch !== 2'd3 || if1.out_data !== 8'h13) begin n_fail++; $display("FAIL resume_out got v=%b ch=%0d d=%h exp v=1 ch=3 d=13", if1.out_valid, if1.out_ch, if1.out_data); end
        if1.in_valid = 4'b0000;
    endtask

    task automatic test_reset_midstream();
        if1.in_valid = 4'b0000; if1.out_ready = 1'b1; if1.in_data = 32'h13121110;
        do_reset();
        if1.in_valid = 4'b1111;
        step();
        step();
        n_checks++; if (if1.out_valid !== 1'b1 || if1.out_ch !== 2'd1) begin n_fail++; $display("FAIL mid_pre got v=%b ch=%0d exp v=1 ch=1", if1.out_valid, if1.out_ch); end
        if1.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (if1.in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_in_ready got=%b exp=0000", if1.in_ready); end
        step();
        n_checks++; if (if1.out_valid !== 1'b0 || if1.out_data !== 8'h00 || if1.out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_rst_out got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", if1.out_valid, if1.out_data, if1.out_ch); end
        rst = 1'b0;
        if1.out_ready = 1'b1;
        #1;
        n_checks++; if (if1.in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", if1.in_ready); end
        step();
        n_checks++; if (if1.out_valid !== 1'b1 || if1.out_ch !== 2'd0 || if1.out_data !== 8'h10) begin n_fail++; $display("FAIL mid_first_word got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", if1.out_valid, if1.out_ch, if1.out_data); end
        if1.in_valid = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        if0.in_valid = '0; if0.in_data = '0; if0.sel = '0; if0.out_ready = 1'b0;
        if1.in_valid = '0; if1.in_data = '0; if1.sel = '0; if1.out_ready = 1'b0;
        test_reset();
        test_mode0_select();
        test_fairness();
        test_backpressure();
        test_sparse_rr();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
